// File: rtl/cpu_check_monitor.sv
// Self-check monitor for the single-cycle cpu: detects halt (PC stable), then compares
// snooped register writes against expected values. Define MONITOR_WRCOUNT_EN for wr_count_o.
module cpu_check_monitor #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NCHECK  = 4,
  parameter int unsigned TIMEOUT = 2000,
  parameter int unsigned STABLE  = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [WIDTH-1:0]        pc_i,
  input  logic                    rf_we_i,
  input  logic [4:0]              rf_waddr_i,
  input  logic [WIDTH-1:0]        rf_wdata_i,
  input  logic [NCHECK*5-1:0]     exp_addr_i,
  input  logic [NCHECK*WIDTH-1:0] exp_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    passed_o,
  output logic                    timeout_o,
  output logic [NCHECK-1:0]       fail_mask_o,
  output logic [15:0]             cycle_count_o,
  output logic [15:0]             wr_count_o
);

  localparam int unsigned CW = 16;
  localparam int unsigned SW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_N = SW'(STABLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [4:0]        exp_addr_q [NCHECK];
  logic [WIDTH-1:0]  exp_data_q [NCHECK];
  logic [WIDTH-1:0]  shadow_q   [NCHECK];
  logic [WIDTH-1:0]  pc_prev_q;
  logic              pc_prev_vld_q;
  logic [SW-1:0]     stable_q;
  logic [CW-1:0]     cycle_q;
  logic              busy_q;
  logic              done_q;
  logic              passed_q;
  logic              timeout_q;
  logic [NCHECK-1:0] fail_mask_q;

  logic              start_c;
  logic              pc_same_c;
  logic              halt_c;
  logic              timeout_c;
  logic [SW-1:0]     stable_d;
  logic [NCHECK-1:0] hit_c;
  logic [NCHECK-1:0] mismatch_c;

  // Per-cycle decode: start acceptance, halt/timeout detection, slot matches
  always_comb begin
    start_c    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    pc_same_c  = pc_prev_vld_q && (pc_i == pc_prev_q);
    stable_d   = pc_same_c ? (stable_q + SW'(1)) : '0;
    halt_c     = (state_q == S_RUN) && pc_same_c && (stable_d == STABLE_N);
    timeout_c  = (state_q == S_RUN) && !halt_c && (cycle_q == TO_LAST);
    hit_c      = '0;
    mismatch_c = '0;
    for (int i = 0; i < int'(NCHECK); i++) begin
      hit_c[i]      = rf_we_i && (rf_waddr_i != 5'd0) && (rf_waddr_i == exp_addr_q[i]);
      mismatch_c[i] = (shadow_q[i] != exp_data_q[i]);
    end
  end

  // Main FSM with registered results
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      pc_prev_q     <= '0;
      pc_prev_vld_q <= 1'b0;
      stable_q      <= '0;
      cycle_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      passed_q      <= 1'b0;
      timeout_q     <= 1'b0;
      fail_mask_q   <= '0;
      for (int i = 0; i < int'(NCHECK); i++) begin
        exp_addr_q[i] <= '0;
        exp_data_q[i] <= '0;
        shadow_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_c) begin
            state_q       <= S_RUN;
            pc_prev_vld_q <= 1'b0;
            stable_q      <= '0;
            cycle_q       <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            passed_q      <= 1'b0;
            timeout_q     <= 1'b0;
            fail_mask_q   <= '0;
            for (int i = 0; i < int'(NCHECK); i++) begin
              exp_addr_q[i] <= exp_addr_i[5*i +: 5];
              exp_data_q[i] <= exp_data_i[WIDTH*i +: WIDTH];
              shadow_q[i]   <= '0;
            end
          end
        end

        S_RUN: begin
          pc_prev_q     <= pc_i;
          pc_prev_vld_q <= 1'b1;
          stable_q      <= stable_d;
          for (int i = 0; i < int'(NCHECK); i++) begin
            if (hit_c[i]) shadow_q[i] <= rf_wdata_i;
          end
          if (halt_c) begin
            state_q <= S_CHECK;
          end else if (timeout_c) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            timeout_q   <= 1'b1;
            passed_q    <= 1'b0;
            fail_mask_q <= '1;
          end else if (cycle_q != CNT_MAX) begin
            // Only cycles that stay in RUN are counted, so the count freezes on exit
            cycle_q <= cycle_q + CW'(1);
          end
        end

        S_CHECK: begin
          state_q     <= S_DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          fail_mask_q <= mismatch_c;
          passed_q    <= (mismatch_c == '0);
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MONITOR_WRCOUNT_EN
  logic [CW-1:0] wr_q;

  // Counts non-zero-address writes seen while running
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
    end else if (start_c) begin
      wr_q <= '0;
    end else if ((state_q == S_RUN) && rf_we_i && (rf_waddr_i != 5'd0) && (wr_q != CNT_MAX)) begin
      wr_q <= wr_q + CW'(1);
    end
  end

  assign wr_count_o = wr_q;
`else
  assign wr_count_o = '0;
`endif

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign passed_o      = passed_q;
  assign timeout_o     = timeout_q;
  assign fail_mask_o   = fail_mask_q;
  assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_cpu_check_monitor.sv
// Directed self-checking bench for cpu_check_monitor (TIMEOUT=50, STABLE=3, NCHECK=4).
module tb_cpu_check_monitor;

  localparam int unsigned W  = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned TO = 50;
  localparam int unsigned ST = 3;
`ifdef MONITOR_WRCOUNT_EN
  localparam logic [31:0] WR_EXP = 32'd5;
`else
  localparam logic [31:0] WR_EXP = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [W-1:0]     pc;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [W-1:0]     rf_wdata;
  logic [NC*5-1:0]  exp_addr;
  logic [NC*W-1:0]  exp_data;
  logic             busy;
  logic             done;
  logic             passed;
  logic             timeout;
  logic [NC-1:0]    fail_mask;
  logic [15:0]      cycle_count;
  logic [15:0]      wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_check_monitor #(
    .WIDTH  (W),
    .NCHECK (NC),
    .TIMEOUT(TO),
    .STABLE (ST)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .pc_i         (pc),
    .rf_we_i      (rf_we),
    .rf_waddr_i   (rf_waddr),
    .rf_wdata_i   (rf_wdata),
    .exp_addr_i   (exp_addr),
    .exp_data_i   (exp_data),
    .busy_o       (busy),
    .done_o       (done),
    .passed_o     (passed),
    .timeout_o    (timeout),
    .fail_mask_o  (fail_mask),
    .cycle_count_o(cycle_count),
    .wr_count_o   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] p, input logic we, input logic [4:0] a, input logic [31:0] d);
    pc       = p;
    rf_we    = we;
    rf_waddr = a;
    rf_wdata = d;
    cyc();
  endtask

  task automatic set_slot(input int i, input logic [4:0] a, input logic [31:0] d);
    exp_addr[5*i +: 5] = a;
    exp_data[W*i +: W] = d;
  endtask

  task automatic clear_slots();
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic start_run();
    start = 1'b1;
    rf_we = 1'b0;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int edges;
    edges = 0;
    rf_we = 1'b0;
    while (!done && edges < budget) begin
      cyc();
      edges++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic p, input logic t,
                              input logic [3:0] m, input logic [15:0] c);
    check({tag, "_passed"},  32'(passed),      32'(p));
    check({tag, "_timeout"}, 32'(timeout),     32'(t));
    check({tag, "_mask"},    32'(fail_mask),   32'(m));
    check({tag, "_cycles"},  32'(cycle_count), 32'(c));
    check({tag, "_busy"},    32'(busy),        32'd0);
  endtask

  initial begin
    int edges;
    logic [31:0] p;

    reset = 1'b1; start = 1'b0; pc = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    clear_slots();
    cyc(); cyc();
    check("rst_flags", 32'({busy, done, passed, timeout, fail_mask}), 32'd0);
    check("rst_cycles", 32'(cycle_count), 32'd0);
    check("rst_wr", 32'(wr_count), 32'd0);
    reset = 1'b0;
    cyc();

    // Simple pass, exact halt latency; expected values are latched at start
    set_slot(0, 5'd2, 32'd4);
    start_run();
    check("t1_busy_start", 32'(busy), 32'd1);
    check("t1_cnt_start", 32'(cycle_count), 32'd0);
    set_slot(0, 5'd2, 32'd5);
    step(32'h10, 1'b1, 5'd2, 32'd4);
    step(32'h20, 1'b0, 5'd0, 32'd0);
    step(32'h20, 1'b0, 5'd0, 32'd0);
    step(32'h20, 1'b0, 5'd0, 32'd0);
    check("t1_run_nodone", 32'({busy, done}), 32'b10);
    step(32'h20, 1'b0, 5'd0, 32'd0);
    check("t1_check_state", 32'({busy, done}), 32'b10);
    step(32'h20, 1'b0, 5'd0, 32'd0);
    check("t1_done_edge", 32'(done), 32'd1);
    check_result("t1", 1'b1, 1'b0, 4'b0000, 16'd4);

    // DONE holds; mismatch run re-armed from DONE, start during RUN ignored
    step(32'h20, 1'b0, 5'd0, 32'd0);
    step(32'h24, 1'b0, 5'd0, 32'd0);
    check("t2_hold", 32'({done, passed}), 32'b11);
    clear_slots();
    set_slot(0, 5'd2, 32'd4);
    set_slot(1, 5'd3, 32'd58);
    start_run();
    check("t2_rearm", 32'({busy, done}), 32'b10);
    step(32'h10, 1'b1, 5'd2, 32'd4);
    step(32'h14, 1'b1, 5'd3, 32'd57);
    start = 1'b1;
    step(32'h20, 1'b0, 5'd0, 32'd0);
    start = 1'b0;
    wait_done("t2", 20);
    check_result("t2", 1'b0, 1'b0, 4'b0010, 16'd5);

    // Shared address in two slots, reg0 slot, write on halt edge, writes in CHECK/DONE ignored
    clear_slots();
    set_slot(0, 5'd5, 32'hAA);
    set_slot(1, 5'd7, 32'h11);
    set_slot(2, 5'd5, 32'hAA);
    set_slot(3, 5'd0, 32'h0);
    start_run();
    step(32'h10, 1'b1, 5'd5,  32'hAA);
    step(32'h14, 1'b1, 5'd9,  32'h1);
    step(32'h18, 1'b1, 5'd10, 32'h2);
    step(32'h30, 1'b1, 5'd0,  32'h55);
    step(32'h30, 1'b1, 5'd11, 32'h3);
    step(32'h30, 1'b1, 5'd0,  32'h66);
    step(32'h30, 1'b1, 5'd7,  32'h11);
    check("t3_halt_busy", 32'({busy, done}), 32'b10);
    step(32'h30, 1'b1, 5'd7,  32'h99);
    check("t3_done_edge", 32'(done), 32'd1);
    check_result("t3", 1'b1, 1'b0, 4'b0000, 16'd6);
    check("t3_wr", 32'(wr_count), WR_EXP);
    step(32'h34, 1'b1, 5'd9, 32'h4);
    step(32'h38, 1'b0, 5'd0, 32'h0);
    check("t3_wr_frozen", 32'(wr_count), WR_EXP);

    // Timeout with ever-changing PC: done exactly TO edges after start
    clear_slots();
    start_run();
    edges = 0;
    p = 32'h100;
    while (!done && edges < 200) begin
      p = p + 32'd4;
      step(p, 1'b0, 5'd0, 32'd0);
      edges++;
    end
    check("t4_edges", 32'(edges), 32'(TO));
    check_result("t4", 1'b0, 1'b1, 4'b1111, 16'(TO - 1));

    // Halt detected exactly on the last RUN cycle: CHECK wins over timeout
    start_run();
    edges = 0;
    while (!done && edges < 200) begin
      p = (edges + 1 < 47) ? 32'(4 * (edges + 1)) : 32'h1000;
      step(p, 1'b0, 5'd0, 32'd0);
      edges++;
    end
    check("t5_edges", 32'(edges), 32'(TO + 1));
    check_result("t5", 1'b1, 1'b0, 4'b0000, 16'(TO - 1));

    // One cycle too late for halt: timeout instead
    start_run();
    edges = 0;
    while (!done && edges < 200) begin
      p = (edges + 1 < 48) ? 32'(4 * (edges + 1)) : 32'h2000;
      step(p, 1'b0, 5'd0, 32'd0);
      edges++;
    end
    check("t5b_edges", 32'(edges), 32'(TO));
    check_result("t5b", 1'b0, 1'b1, 4'b1111, 16'(TO - 1));

    // Reset mid-RUN aborts; a fresh start counts from zero
    set_slot(0, 5'd2, 32'd4);
    start_run();
    for (int j = 1; j <= 10; j++) step(32'(8 * j), 1'b1, 5'd2, 32'd4);
    reset = 1'b1;
    step(32'h400, 1'b0, 5'd0, 32'd0);
    check("t6_rst_flags", 32'({busy, done, passed, timeout, fail_mask}), 32'd0);
    check("t6_rst_cycles", 32'(cycle_count), 32'd0);
    check("t6_rst_wr", 32'(wr_count), 32'd0);
    reset = 1'b0;
    cyc();
    start_run();
    check("t6_cnt_start", 32'(cycle_count), 32'd0);
    step(32'h10, 1'b1, 5'd2, 32'd4);
    step(32'h20, 1'b0, 5'd0, 32'd0);
    wait_done("t6", 20);
    check_result("t6", 1'b1, 1'b0, 4'b0000, 16'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
